aes_decrypt_iter: RTL and testbench

- Iterative AES-128 decryption core; the inverse of the pipelined encryption datapath.
- Accepts one ciphertext block and its cipher key, expands the key internally and runs the 10 inverse rounds one per clock.
- Returns the plaintext with a one-cycle done pulse.
- Sits beside the encryptor at the top level. Small area, with a start/busy/done handshake instead of full pipelining.

---
 rtl/aes_decrypt_iter.sv | 180 ++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key one round key per clock, then runs one inverse round per clock.
// Latency is 21 cycles from start to done, or 11 when the previous expanded key is reused; start is ignored while busy.
module aes_decrypt_iter #(
  parameter bit CACHE_KEY = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  typedef enum logic [2:0] {IDLE, KEYEXP, ADDK, ROUND, FINAL} state_t;

  state_t       st, st_nxt;
  logic [127:0] rk [0:10];
  logic [127:0] blk;
  logic [127:0] sub_sh;
  logic [3:0]   cnt;
  logic         key_valid;
  logic         cache_hit;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x63, x126, x127;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x63  = gf_mul(x60, x3);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte i sits at [127-8i -: 8]; row = i%4, column = i/4.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Compared against the old k0 before this start overwrites it.
  assign cache_hit = CACHE_KEY && key_valid && (key_in == rk[0]);
  assign sub_sh    = inv_shift_sub(blk);

  always_ff @(posedge CLK) begin
    if (RST) st <= IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (start) st_nxt = cache_hit ? ADDK : KEYEXP;
      KEYEXP:  if (cnt == 4'd10) st_nxt = ADDK;
      ADDK:    st_nxt = ROUND;
      ROUND:   if (cnt == 4'd1) st_nxt = FINAL;
      FINAL:   st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      key_valid <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          blk   <= data_in;
          rk[0] <= key_in;
          busy  <= 1'b1;
          if (!cache_hit) begin
            key_valid <= 1'b0;
            cnt       <= 4'd1;
          end
        end
        KEYEXP: begin
          rk[cnt] <= key_step(rk[cnt - 4'd1], rcon(cnt));
          if (cnt == 4'd10) key_valid <= 1'b1;
          else              cnt <= cnt + 4'd1;
        end
        ADDK: begin
          blk <= blk ^ rk[10];
          cnt <= 4'd9;
        end
        ROUND: begin
          blk <= inv_mix(sub_sh ^ rk[cnt]);
          cnt <= cnt - 4'd1;
        end
        FINAL: begin
          data_out <= sub_sh ^ rk[0];
          done     <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: known-answer table, handshake corner cases, and a
// random round trip against an in-bench AES-128 encryptor.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst, start, sel;
  logic [127:0] key_in, data_in;
  logic         start_c, start_n, busy_c, busy_n, done_c, done_n;
  logic [127:0] out_c, out_n;
  logic         cur_busy, cur_done;
  logic [127:0] cur_out;

  always #5 clk = ~clk;

  assign start_c  = start & ~sel;
  assign start_n  = start & sel;
  assign cur_busy = sel ? busy_n : busy_c;
  assign cur_done = sel ? done_n : done_c;
  assign cur_out  = sel ? out_n : out_c;

  aes_decrypt_iter #(.CACHE_KEY(1'b1)) dut (
    .CLK(clk), .RST(rst), .start(start_c), .key_in(key_in), .data_in(data_in),
    .busy(busy_c), .done(done_c), .data_out(out_c));

  aes_decrypt_iter #(.CACHE_KEY(1'b0)) dut_nc (
    .CLK(clk), .RST(rst), .start(start_n), .key_in(key_in), .data_in(data_in),
    .busy(busy_n), .done(done_n), .data_out(out_n));

  int n_chk = 0;
  int n_fail = 0;
  int done_count = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cur_done) begin
      done_count++;
      check("done_without_busy", cur_busy, 0);
      check("done_single_cycle", prev_done, 0);
    end
    prev_done = cur_done;
  end

  // Reference model: forward S-box built by walking the multiplicative group.
  logic [7:0] sb [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xtime(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Call at a negedge with the selected core idle (or in its done cycle).
  task automatic launch(input logic [127:0] key, input logic [127:0] data, input string name);
    key_in  = key;
    data_in = data;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({name, " busy_after_start"}, cur_busy, 1);
  endtask

  task automatic wait_done(input logic [127:0] exp_pt, input int exp_lat, input string name, input bit inject);
    int           lat;
    logic [127:0] hold;
    bit           stable;
    hold   = cur_out;
    stable = 1'b1;
    lat    = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (inject && (lat == 5 || lat == 15)) begin
        start   = 1'b1;
        data_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      if (!cur_done && cur_out !== hold) stable = 1'b0;
    end while (!cur_done && lat < 40);
    start = 1'b0;
    check({name, " latency"}, lat, exp_lat);
    check({name, " data_out"}, cur_out, exp_pt);
    check({name, " data_out_held"}, stable, 1);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           lat;
    bit           b2b;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    vec_t         tv [5];
    int           dc0, lat;
    logic [127:0] mkey, key, pt;

    tv[0] = '{C1_KEY, C1_CT, C1_PT, 21, 1'b0};
    tv[1] = '{B_KEY,  B_CT,  B_PT,  21, 1'b0};
    tv[2] = '{B_KEY,  B_CT,  B_PT,  11, 1'b1};
    tv[3] = '{C1_KEY, C1_CT, C1_PT, 21, 1'b1};
    tv[4] = '{C1_KEY, C1_CT, C1_PT, 11, 1'b0};

    build_sbox();
    rst = 1'b1; start = 1'b0; sel = 1'b0; key_in = '0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy_c, 0);
    check("reset done", done_c, 0);
    check("reset data_out", out_c, 0);
    check("reset nc data_out", out_n, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (!tv[i].b2b) repeat (2) @(negedge clk);
      launch(tv[i].key, tv[i].ct, $sformatf("vec%0d", i));
      wait_done(tv[i].pt, tv[i].lat, $sformatf("vec%0d", i), 1'b0);
    end

    // Same key back-to-back on the non-caching core still expands.
    repeat (2) @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    launch(B_KEY, B_CT, "nocache0");
    wait_done(B_PT, 21, "nocache0", 1'b0);
    launch(B_KEY, B_CT, "nocache1");
    wait_done(B_PT, 21, "nocache1", 1'b0);
    repeat (2) @(negedge clk);
    sel = 1'b0;
    @(negedge clk);

    // Starts pulsed mid-operation must be ignored.
    dc0 = done_count;
    launch(B_KEY, B_CT, "ignore");
    wait_done(B_PT, 21, "ignore", 1'b1);
    repeat (30) @(negedge clk);
    check("ignore done_pulses", done_count - dc0, 1);

    // Reset mid-operation, after the key cache would already be valid.
    launch(C1_KEY, C1_CT, "abort");
    repeat (11) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy_c, 0);
    check("abort done", done_c, 0);
    check("abort data_out", out_c, 0);
    dc0 = done_count;
    repeat (30) @(negedge clk);
    check("abort no_done", done_count - dc0, 0);
    launch(C1_KEY, C1_CT, "after_abort");
    wait_done(C1_PT, 21, "after_abort", 1'b0);

    // Random round trip; the model tracks which key the core last expanded.
    mkey = C1_KEY;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(2) == 0) key = mkey;
      else key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      lat = (key == mkey) ? 11 : 21;
      repeat ($urandom_range(2)) @(negedge clk);
      launch(key, aes_enc(pt, key), $sformatf("rand%0d", i));
      wait_done(pt, lat, $sformatf("rand%0d", i), 1'b0);
      mkey = key;
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
